// File: rtl/line_fill_responder.sv
// ---------------------------------------------------------------------------
// line_fill_responder
//
// Purpose: services one cache line fill at a time. A request (tag/index/
// critical word) is captured in IDLE, sixteen word reads are issued to memory
// in FETCH while the in-order read data is collected into a line register,
// and the completed line is offered to the cache in DELIVER until it is
// accepted.
//
// Optional feature (compile-time macro LINE_FILL_CRITICAL_WORD_FIRST_EN):
//   defined   -> the burst starts at the requested word and wraps (critical
//                word first).
//   undefined -> the burst always starts at word 0 and req_word is ignored.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clock edge where both valid and ready are high. Once valid rises it stays
// high, with its payload unchanged, until that transfer happens. The read
// data return (mem_rdata_valid) has no ready and is always accepted while a
// fill is collecting.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   line fill request; req_tag = addr[31:14],
//                     req_index = addr[13:6], req_word = addr[5:2]
//   mem_req_valid/    word read address channel; mem_addr is word aligned
//   mem_req_ready
//   mem_rdata_valid,  in-order read data return
//   mem_rdata
//   fill_valid/ready  completed line with fill_index, fill_tag, fill_data
//   busy              high whenever a fill is in progress (not IDLE)
//   state_dbg         current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
module line_fill_responder #(
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // request channel
  input  logic                  req_valid,
  input  logic [17:0]           req_tag,
  input  logic [7:0]            req_index,
  input  logic [3:0]            req_word,
  output logic                  req_ready,
  // memory read channel
  output logic                  mem_req_valid,
  output logic [31:0]           mem_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rdata_valid,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  // fill channel
  output logic                  fill_valid,
  input  logic                  fill_ready,
  output logic [7:0]            fill_index,
  output logic [17:0]           fill_tag,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
  localparam int SLOT_W = 4;
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF_EN = 1'b1;
`else
  localparam bit CWF_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [17:0]           tag_q, tag_d;
  logic [7:0]            index_q, index_d;
  logic [SLOT_W-1:0]     start_q, start_d;
  logic [CNT_W-1:0]      issue_q, issue_d;
  logic [CNT_W-1:0]      recv_q, recv_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;

  logic                  issue_fire;
  logic                  recv_fire;
  logic [SLOT_W-1:0]     issue_slot;
  logic [SLOT_W-1:0]     recv_slot;

  // Slots wrap modulo 16 because the sum is truncated to SLOT_W bits.
  assign issue_slot = start_q + issue_q[SLOT_W-1:0];
  assign recv_slot  = start_q + recv_q[SLOT_W-1:0];

  // All status outputs come straight from registered state and counters.
  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_FETCH) && (issue_q < BEATS_C);
  assign fill_valid    = (state_q == S_DELIVER);
  assign state_dbg     = state_q;

  // Address is forced to zero when no read is being offered so the bus is
  // quiet outside FETCH.
  assign mem_addr = mem_req_valid ? {tag_q, index_q, issue_slot, 2'b00} : 32'd0;

  assign fill_index = index_q;
  assign fill_tag   = tag_q;
  assign fill_data  = data_q;

  assign issue_fire = mem_req_valid && mem_req_ready;
  // Read data outside FETCH, or after the line is complete, is dropped.
  assign recv_fire  = (state_q == S_FETCH) && mem_rdata_valid && (recv_q < BEATS_C);

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    start_d = start_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tag_d   = req_tag;
          index_d = req_index;
          start_d = CWF_EN ? req_word : '0;
          issue_d = '0;
          recv_d  = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (issue_fire) begin
          issue_d = issue_q + 1'b1;
        end
        if (recv_fire) begin
          recv_d = recv_q + 1'b1;
          for (int k = 0; k < BEATS; k++) begin
            if (recv_slot == SLOT_W'(k)) begin
              data_d[k*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
            end
          end
          if (recv_q == LAST_C) begin
            state_d = S_DELIVER;
          end
        end
      end

      S_DELIVER: begin
        if (fill_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      start_q <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      start_q <= start_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// ---------------------------------------------------------------------------
// tb_line_fill_responder
//
// Self-checking bench for line_fill_responder. The reference model is a list
// of the sixteen word addresses a fill must produce and the line image built
// from a memory content function; the bench plays the memory (in-order data
// after a configurable latency) and compares every issued address and the
// delivered line against the model.
// ---------------------------------------------------------------------------
module tb_line_fill_responder;

  localparam int LW = 512;
  localparam int WW = 32;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [17:0]   req_tag = '0;
  logic [7:0]    req_index = '0;
  logic [3:0]    req_word = '0;
  logic          req_ready;
  logic          mem_req_valid;
  logic [31:0]   mem_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_rdata_valid = 1'b0;
  logic [WW-1:0] mem_rdata = '0;
  logic          fill_valid;
  logic          fill_ready = 1'b0;
  logic [7:0]    fill_index;
  logic [17:0]   fill_tag;
  logic [LW-1:0] fill_data;
  logic          busy;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // memory content selector
  bit          simple_data = 1'b1;
  logic [31:0] data_seed = 32'h0;

  // outstanding reads held by the memory model
  int          pend_due[$];
  logic [31:0] pend_addr[$];

  line_fill_responder #(.LINE_WIDTH(LW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag), .req_index(req_index),
    .req_word(req_word), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr),
    .mem_req_ready(mem_req_ready), .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] word_addr(input logic [17:0] tag,
                                            input logic [7:0] idx,
                                            input int slot);
    logic [3:0] s;
    s = 4'(slot % 16);
    return {tag, idx, s, 2'b00};
  endfunction

  function automatic logic [31:0] data_for(input logic [31:0] addr);
    if (simple_data) return 32'h1000 + {28'd0, addr[5:2]};
    return (addr * 32'h9E37_79B1) ^ data_seed;
  endfunction

  // One full fill: request, fetch with the memory model, optional delivery
  // stall. rmode: 0 always ready, 1 toggling, 2 random. abort_after > 0
  // applies reset once that many beats have been returned.
  task automatic do_fill(input logic [17:0] tag, input logic [7:0] idx,
                         input logic [3:0] word, input int rmode,
                         input int lat, input int hold, input int abort_after,
                         input string nm);
    logic [31:0]   exp_addr_q[$];
    logic [LW-1:0] exp_line;
    logic [LW-1:0] held_data;
    int            start, issued, recvd, cyc;
    logic [31:0]   a;

    start = CWF ? int'(word) : 0;
    for (int i = 0; i < 16; i++) exp_addr_q.push_back(word_addr(tag, idx, start + i));
    for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = data_for(word_addr(tag, idx, k));
    pend_due.delete();
    pend_addr.delete();

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_idle: got %0b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_tag = tag; req_index = idx; req_word = word;
    @(posedge clk);

    issued = 0; recvd = 0; cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_tag = 18'($urandom); req_index = 8'($urandom); req_word = 4'($urandom);
      if (fill_valid) break;
      if (abort_after > 0 && recvd == abort_after) begin
        reset = 1'b1; mem_rdata_valid = 1'b0; mem_req_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || fill_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
            mem_addr !== 32'd0 || fill_index !== 8'd0 || fill_tag !== 18'd0 ||
            fill_data !== '0 || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s abort_reset: busy=%0b fv=%0b mrv=%0b addr=%h idx=%h tag=%h rr=%0b data_zero=%0b want 0,0,0,0,0,0,1,1",
                   nm, busy, fill_valid, mem_req_valid, mem_addr, fill_index, fill_tag,
                   req_ready, (fill_data == '0));
        end
        return;
      end
      case (rmode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = (cyc % 2 == 0);
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        void'(pend_due.pop_front());
        a = pend_addr.pop_front();
        mem_rdata_valid = 1'b1;
        mem_rdata = data_for(a);
        recvd++;
      end else begin
        mem_rdata_valid = 1'b0;
        mem_rdata = $urandom;
      end
      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_issue: addr=%h beyond 16 issues", nm, mem_addr);
        end else begin
          a = exp_addr_q.pop_front();
          if (mem_addr !== a) begin
            errors++;
            $display("FAIL %s mem_addr[%0d]: got %h want %h", nm, issued, mem_addr, a);
          end
        end
        issued++;
        pend_due.push_back(cyc + lat);
        pend_addr.push_back(mem_addr);
      end
      @(posedge clk);
      cyc++;
    end
    mem_rdata_valid = 1'b0;
    mem_req_ready = 1'b0;

    checks++;
    if (fill_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s fill_timeout: fill_valid=%0b after %0d cycles want 1", nm, fill_valid, cyc);
      return;
    end
    checks++;
    if (issued != 16 || recvd != 16) begin
      errors++;
      $display("FAIL %s beat_counts: issued=%0d recvd=%0d want 16,16", nm, issued, recvd);
    end
    checks++;
    if (fill_data !== exp_line) begin
      errors++;
      $display("FAIL %s fill_data: got %h want %h", nm, fill_data, exp_line);
    end
    checks++;
    if (fill_index !== idx || fill_tag !== tag) begin
      errors++;
      $display("FAIL %s fill_ids: idx=%h tag=%h want %h %h", nm, fill_index, fill_tag, idx, tag);
    end
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s deliver_status: busy=%0b rr=%0b mrv=%0b want 1,0,0", nm, busy, req_ready, mem_req_valid);
    end

    held_data = fill_data;
    for (int h = 0; h < hold; h++) begin
      fill_ready = 1'b0;
      // a spurious beat while delivering must not disturb the line
      mem_rdata_valid = 1'($urandom_range(0, 1));
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      mem_rdata_valid = 1'b0;
      checks++;
      if (fill_valid !== 1'b1 || fill_data !== held_data || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: fv=%0b rr=%0b stable=%0b want 1,0,1", nm, h,
                 fill_valid, req_ready, (fill_data === held_data));
      end
    end
    fill_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fill_ready = 1'b0;
    checks++;
    if (fill_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake: fv=%0b rr=%0b busy=%0b want 0,1,0", nm, fill_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || fill_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_addr !== 32'd0 || fill_index !== 8'd0 || fill_tag !== 18'd0 ||
        fill_data !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: busy=%0b fv=%0b mrv=%0b addr=%h idx=%h tag=%h rr=%0b want 0,0,0,0,0,0,1",
               busy, fill_valid, mem_req_valid, mem_addr, fill_index, fill_tag, req_ready);
    end
  endtask

  task automatic test_basic_fill();
    simple_data = 1'b1;
    do_fill(18'h00001, 8'h05, 4'd3, 0, 1, 0, 0, "basic");
  endtask

  task automatic test_deliver_stall();
    simple_data = 1'b1;
    do_fill(18'h00001, 8'h05, 4'd3, 0, 2, 10, 0, "stall");
  endtask

  task automatic test_toggle_ready();
    simple_data = 1'b0;
    data_seed = $urandom;
    do_fill(18'($urandom), 8'($urandom), 4'($urandom), 1, 3, 0, 0, "toggle");
  endtask

  task automatic test_abort();
    simple_data = 1'b0;
    data_seed = $urandom;
    do_fill(18'h2A5A5, 8'h7F, 4'd9, 0, 3, 0, 7, "abort");
    // the remaining beats of the aborted burst arrive late and must be ignored
    for (int i = 0; i < 9; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_late_beat[%0d]: busy=%0b mrv=%0b rr=%0b want 0,0,1", i, busy, mem_req_valid, req_ready);
      end
    end
    mem_rdata_valid = 1'b0;
    do_fill(18'h00ABC, 8'h33, 4'd15, 0, 1, 0, 0, "after_abort");
  endtask

  task automatic test_spurious_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rdata_valid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      mem_rdata_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL spurious_idle[%0d]: busy=%0b rr=%0b st=%0d want 0,1,0", i, busy, req_ready, state_dbg);
      end
    end
    simple_data = 1'b1;
    do_fill(18'h00001, 8'h05, 4'd0, 0, 1, 0, 0, "post_spurious");
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (fill_data[k*32 +: 32] === 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL spurious_word[%0d]: got %h want not DEADBEEF", k, fill_data[k*32 +: 32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    simple_data = 1'b0;
    for (int n = 0; n < 6; n++) begin
      data_seed = $urandom;
      do_fill(18'($urandom), 8'($urandom), 4'($urandom), 2,
              $urandom_range(1, 6), $urandom_range(0, 3), 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_deliver_stall();
    test_toggle_ready();
    test_abort();
    test_spurious_idle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog so the bench always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
